// File: rtl/program_memory_arbiter.sv
`timescale 1ns/1ps
// Purpose: two-master arbiter (round-robin, m1 lock for loader) in front of a single-port program RAM.
// Latency: grant and mem_* are combinational; read data returns exactly 1 cycle after acceptance.
// Backpressure: waitrequest=1 for losers, for m0 while locked, and for everyone while freeze=1.
module program_memory_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 37500,
    parameter int LOCK_MAX = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  freeze,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  oor_err,
    output logic                  lock_timeout
);

    // Timer only needs to reach LOCK_MAX-1: the LOCK_MAX-th locked cycle is the last one.
    localparam int TMR_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(LOCK_MAX - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;          // 1: m1 wins a tie
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               relock_blk_q, relock_blk_d;
    logic               oor_err_q, oor_err_d;
    logic               lock_to_q, lock_to_d;
    logic               rvld0_q, rvld0_d;
    logic               rvld1_q, rvld1_d;
    logic               roor_q, roor_d;

    logic               req0, req1;
    logic               gnt0, gnt1;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_read, sel_write, sel_oor;
    logic               acc_rd;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant selection: nothing during reset or freeze, m1 only when locked, round-robin otherwise.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !freeze) begin
            if (state_q == ST_LOCKED) begin
                gnt1 = req1;
            end else if (req0 && req1) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign sel_addr  = gnt1 ? m1_address : m0_address;
    assign sel_read  = gnt1 ? m1_read    : m0_read;
    assign sel_write = gnt1 ? m1_write   : m0_write;
    assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_X);

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    assign mem_address    = sel_addr;
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = gnt0 | gnt1;
    assign mem_write      = mem_chipselect & sel_write & ~sel_oor;
    assign mem_clken      = ~freeze;

    // Read+write together performs only the write, so it never produces a return.
    assign acc_rd = mem_chipselect & sel_read & ~sel_write;

    assign m0_readdatavalid = rvld0_q;
    assign m1_readdatavalid = rvld1_q;
    assign m0_readdata      = (rvld0_q && !roor_q) ? mem_readdata : '0;
    assign m1_readdata      = (rvld1_q && !roor_q) ? mem_readdata : '0;
    assign oor_err          = oor_err_q;
    assign lock_timeout     = lock_to_q;

    // Next-state: lock FSM, lock timer, round-robin pointer, read-return pipe and sticky flags.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        timer_d      = timer_q;
        relock_blk_d = relock_blk_q;
        oor_err_d    = oor_err_q;
        lock_to_d    = lock_to_q;
        rvld0_d      = gnt0 & acc_rd;
        rvld1_d      = gnt1 & acc_rd;
        roor_d       = acc_rd & sel_oor;

        if (mem_chipselect) begin
            prio_d = gnt0;
        end
        if (mem_chipselect && sel_oor) begin
            oor_err_d = 1'b1;
        end
        if (!m1_lock) begin
            relock_blk_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt1 && m1_lock && !relock_blk_q) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!m1_lock) begin
                    state_d = ST_IDLE;
                end else if (!freeze) begin
                    if (timer_q == TMR_LAST) begin
                        state_d      = ST_IDLE;
                        timer_d      = '0;
                        lock_to_d    = 1'b1;
                        relock_blk_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also drops any read return still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            timer_q      <= '0;
            relock_blk_q <= 1'b0;
            oor_err_q    <= 1'b0;
            lock_to_q    <= 1'b0;
            rvld0_q      <= 1'b0;
            rvld1_q      <= 1'b0;
            roor_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            timer_q      <= timer_d;
            relock_blk_q <= relock_blk_d;
            oor_err_q    <= oor_err_d;
            lock_to_q    <= lock_to_d;
            rvld0_q      <= rvld0_d;
            rvld1_q      <= rvld1_d;
            roor_q       <= roor_d;
        end
    end

endmodule

// File: tb/tb_program_memory_arbiter.sv
`timescale 1ns/1ps
// Bench for program_memory_arbiter: directed cycles drive both masters, expected read returns
// go into a scoreboard queue, and a negedge monitor pops and compares each readdatavalid.
// A behavioural RAM with 1-cycle registered read sits on the mem_* side.
module tb_program_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        freeze;
    logic [15:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write, m1_lock;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [15:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        oor_err, lock_timeout;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] dat;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] ram [0:65535];

    always #5 clk = ~clk;

    program_memory_arbiter #(
        .ADDR_W(16), .DATA_W(32), .DEPTH(37500), .LOCK_MAX(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_lock(m1_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .oor_err(oor_err), .lock_timeout(lock_timeout)
    );

    // RAM contents: word a holds {a ^ 16'h5A5A, ~a}
    initial begin
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] a;
            a = i[15:0];
            ram[i] = {a ^ 16'h5A5A, ~a};
        end
        mem_readdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (m0_readdatavalid && m1_readdatavalid) begin
            n_vec++;
            n_fail++;
            $display("FAIL rdv_both: got both readdatavalid high at %0t", $time);
        end else if (m0_readdatavalid || m1_readdatavalid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rdv_unexpected: got readdatavalid m%0d expected none at %0t",
                         m1_readdatavalid ? 1 : 0, $time);
            end else begin
                e = sb_q.pop_front();
                chk("rd_requester", 32'(m1_readdatavalid), 32'(e.id));
                chk("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.dat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = 16'h0; m0_byteenable = 4'hF; m0_writedata = 32'h0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = 16'h0; m1_byteenable = 4'hF; m1_writedata = 32'h0;
    endtask

    task automatic m0_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic m1_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    endtask

    task automatic push(input logic id, input logic [31:0] d);
        sb_q.push_back({id, d});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m0_wait"}, 32'(m0_waitrequest), 32'd1);
        chk({tag, "_m1_wait"}, 32'(m1_waitrequest), 32'd1);
        chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
        chk({tag, "_mwr"}, 32'(mem_write), 32'd0);
        chk({tag, "_m0_rdv"}, 32'(m0_readdatavalid), 32'd0);
        chk({tag, "_m1_rdv"}, 32'(m1_readdatavalid), 32'd0);
        chk({tag, "_m0_rdata"}, m0_readdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_readdata, 32'd0);
        chk({tag, "_oor"}, 32'(oor_err), 32'd0);
        chk({tag, "_lockto"}, 32'(lock_timeout), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        freeze  = 1'b0;
        m1_lock = 1'b0;
        clr();
        m0_req(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
        m1_req(1'b0, 1'b1, 16'h0010, 4'hF, 32'h1111_1111);
        mid();
        chk_reset_outputs("rst0");
        nxt();
        nxt();
        reset_n = 1'b1;
        clr();
        nxt();

        // Simultaneous reads of 0x0010: m0 first (pointer favours m0), m1 next cycle
        m0_req(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
        m1_req(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
        push(1'b0, 32'h5A4A_FFEF);
        mid();
        chk("rr_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rr_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rr_addr", 32'(mem_address), 32'h0010);
        chk("rr_cs", 32'(mem_chipselect), 32'd1);
        chk("rr_clken", 32'(mem_clken), 32'd1);
        nxt();
        m0_req(1'b0, 1'b0, 16'h0, 4'hF, 32'h0);
        push(1'b1, 32'h5A4A_FFEF);
        mid();
        chk("rr2_m1_wait", 32'(m1_waitrequest), 32'd0);
        nxt();
        clr();

        // Partial write by m1 then readback by m0
        m1_req(1'b0, 1'b1, 16'h0100, 4'h3, 32'hDEAD_BEEF);
        mid();
        chk("bw_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("bw_mwr", 32'(mem_write), 32'd1);
        chk("bw_be", 32'(mem_byteenable), 32'h3);
        nxt();
        clr();
        m0_req(1'b1, 1'b0, 16'h0100, 4'hF, 32'h0);
        push(1'b0, 32'h5B5A_BEEF);
        mid();
        chk("bw_rd_mwr", 32'(mem_write), 32'd0);
        nxt();
        clr();

        // Read and write together: write only, no return
        m0_req(1'b1, 1'b1, 16'h0020, 4'hF, 32'h1234_5678);
        mid();
        chk("rw_mwr", 32'(mem_write), 32'd1);
        nxt();
        clr();
        m1_req(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0);
        push(1'b1, 32'h1234_5678);
        nxt();

        // Back-to-back alternating single requesters
        clr();
        m0_req(1'b1, 1'b0, 16'h0001, 4'hF, 32'h0);
        push(1'b0, 32'h5A5B_FFFE);
        nxt();
        clr();
        m1_req(1'b1, 1'b0, 16'h0002, 4'hF, 32'h0);
        push(1'b1, 32'h5A58_FFFD);
        nxt();
        clr();
        m0_req(1'b1, 1'b0, 16'h0003, 4'hF, 32'h0);
        push(1'b0, 32'h5A59_FFFC);
        nxt();
        clr();
        mid();
        chk("oor_before", 32'(oor_err), 32'd0);

        // Last in-range word, then out-of-range write and read
        nxt();
        m0_req(1'b0, 1'b1, 16'd37499, 4'hF, 32'hCAFE_0001);
        mid();
        chk("edge_mwr", 32'(mem_write), 32'd1);
        nxt();
        m0_req(1'b0, 1'b1, 16'd37500, 4'hF, 32'hCAFE_0002);
        mid();
        chk("oor_wait", 32'(m0_waitrequest), 32'd0);
        chk("oor_cs", 32'(mem_chipselect), 32'd1);
        chk("oor_mwr", 32'(mem_write), 32'd0);
        nxt();
        m0_req(1'b1, 1'b0, 16'd37500, 4'hF, 32'h0);
        push(1'b0, 32'h0);
        mid();
        chk("oor_flag", 32'(oor_err), 32'd1);
        nxt();
        clr();

        // Freeze right after an accepted read
        m0_req(1'b1, 1'b0, 16'h0001, 4'hF, 32'h0);
        push(1'b0, 32'h5A5B_FFFE);
        nxt();
        freeze = 1'b1;
        m0_req(1'b1, 1'b0, 16'h0002, 4'hF, 32'h0);
        m1_req(1'b1, 1'b0, 16'h0003, 4'hF, 32'h0);
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("frz_m0_wait", 32'(m0_waitrequest), 32'd1);
            chk("frz_m1_wait", 32'(m1_waitrequest), 32'd1);
            chk("frz_clken", 32'(mem_clken), 32'd0);
            chk("frz_cs", 32'(mem_chipselect), 32'd0);
            nxt();
        end
        freeze = 1'b0;
        m1_req(1'b0, 1'b0, 16'h0, 4'hF, 32'h0);
        push(1'b0, 32'h5A58_FFFD);
        mid();
        chk("unfrz_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("unfrz_clken", 32'(mem_clken), 32'd1);
        nxt();
        clr();

        // Lock held past LOCK_MAX=8 while m0 waits
        m1_lock = 1'b1;
        m1_req(1'b1, 1'b0, 16'h0003, 4'hF, 32'h0);
        push(1'b1, 32'h5A59_FFFC);
        mid();
        chk("lk_m1_wait", 32'(m1_waitrequest), 32'd0);
        nxt();
        clr();
        m0_req(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
        for (int c = 0; c < 8; c++) begin
            mid();
            chk("lk_m0_stall", 32'(m0_waitrequest), 32'd1);
            nxt();
        end
        m1_req(1'b1, 1'b0, 16'h0002, 4'hF, 32'h0);
        push(1'b0, 32'h5A4A_FFEF);
        mid();
        chk("lk_to_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("lk_to_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("lk_to_flag", 32'(lock_timeout), 32'd1);
        nxt();
        m0_req(1'b0, 1'b0, 16'h0, 4'hF, 32'h0);
        push(1'b1, 32'h5A58_FFFD);
        mid();
        chk("relock_m1_wait", 32'(m1_waitrequest), 32'd0);
        nxt();
        clr();
        m0_req(1'b1, 1'b0, 16'h0001, 4'hF, 32'h0);
        push(1'b0, 32'h5A5B_FFFE);
        mid();
        chk("relock_blk_m0", 32'(m0_waitrequest), 32'd0);
        nxt();
        clr();

        // Normal lock and release via m1_lock low
        m1_lock = 1'b0;
        nxt();
        m1_lock = 1'b1;
        m1_req(1'b1, 1'b0, 16'h0003, 4'hF, 32'h0);
        push(1'b1, 32'h5A59_FFFC);
        nxt();
        clr();
        m1_lock = 1'b0;
        m0_req(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
        mid();
        chk("unlk_m0_still", 32'(m0_waitrequest), 32'd1);
        nxt();
        push(1'b0, 32'h5A4A_FFEF);
        mid();
        chk("unlk_m0_wait", 32'(m0_waitrequest), 32'd0);
        nxt();
        clr();

        // Reset one cycle after an accepted read: return discarded, flags cleared
        m0_req(1'b1, 1'b0, 16'h0001, 4'hF, 32'h0);
        nxt();
        reset_n = 1'b0;
        m0_req(1'b0, 1'b1, 16'h0005, 4'hF, 32'h5555_5555);
        m1_req(1'b1, 1'b0, 16'h0006, 4'hF, 32'h0);
        mid();
        chk_reset_outputs("rst1");
        nxt();
        reset_n = 1'b1;
        clr();
        for (int c = 0; c < 4; c++) nxt();
        mid();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/program_memory_arbiter.md
PROGRAM_MEMORY_ARBITER -- requirements
Module: program_memory_arbiter

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
- ADDR_W, 16, word address width.
- DATA_W, 32, data width.
- DEPTH, 37500, implemented words; addresses >= DEPTH are out of range.
- LOCK_MAX, 1024, maximum consecutive cycles m1 may hold a lock.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- freeze  in  1  stall: no new grants, RAM clock-enable low.
- m0_address / m1_address  in  ADDR_W  requester word address.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m1_lock  in  1  m1 requests exclusive ownership (loader).
- m0_waitrequest / m1_waitrequest  out  1  transfer not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid.
- mem_address  out  ADDR_W  RAM address.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  RAM output; valid 1 cycle after address accepted.
- oor_err  out  1  sticky out-of-range flag.
- lock_timeout  out  1  sticky forced-unlock flag.

Function
REQ-003 SHALL treat requester i as requesting when mi_read | mi_write; a transfer is accepted in any cycle where mi_waitrequest=0 and i requests.
REQ-004 SHALL accept at most one transfer per cycle; non-requesting or losing requesters see waitrequest=1.
REQ-005 SHALL arbitrate round-robin in state IDLE: with one requester, grant it; with both, grant the one not granted last; priority pointer updates only on accepted transfers.
REQ-006 SHALL implement FSM states IDLE and LOCKED: IDLE->LOCKED when m1_lock=1 at an accepted m1 transfer; LOCKED->IDLE when m1_lock=0 or the lock timer reaches LOCK_MAX.
REQ-007 SHALL in LOCKED grant only m1; m0_waitrequest=1 throughout.
REQ-008 SHALL count LOCKED cycles with a timer cleared on entry; at LOCK_MAX force IDLE, set lock_timeout, and block relock until m1_lock has been seen low for one cycle.
REQ-009 SHALL drive mem_* combinationally from the granted requester; mem_chipselect=1 only on accepted transfers; mem_write=1 only on accepted in-range writes.
REQ-010 SHALL, if read and write are both asserted, perform the write only and produce no readdatavalid.
REQ-011 SHALL return read data exactly 1 cycle after acceptance: mi_readdatavalid=1 for that single cycle, mi_readdata=mem_readdata; the other requester's readdatavalid=0.
REQ-012 SHALL support back-to-back reads at one per cycle, including alternating requesters, with in-order returns.
REQ-013 SHALL, for address >= DEPTH, accept the transfer, suppress mem_write, return readdata=0 with readdatavalid on the normal cycle, and set oor_err.
REQ-014 SHALL, while freeze=1, hold mem_clken=0 and both waitrequests=1; a read accepted in the cycle before freeze still returns readdatavalid on schedule; the lock timer holds.
REQ-015 SHALL drive mem_clken=1 when freeze=0.

Reset
REQ-016 SHALL on reset_n=0 immediately force: FSM=IDLE, pointer favours m0, lock timer=0, readdatavalids=0, readdata=0, oor_err=0, lock_timeout=0, waitrequests=1, mem_chipselect=0, mem_write=0.
REQ-017 SHALL discard any read in flight at reset assertion; no readdatavalid after release for it.
REQ-018 SHALL clear sticky flags only by reset.

Verification
REQ-019 Both read addr 0x0010 in the same cycle -> m0 accepted cycle N, m1 at N+1; readdatavalid at N+1 and N+2 with RAM contents.
REQ-020 m1 writes 0xDEADBEEF to 0x0100 with byteenable 0x3, then m0 reads 0x0100 -> returns old[31:16]:0xBEEF.
REQ-021 m1_lock held with LOCK_MAX=8 while m0 requests -> m0 stalled 8 cycles, then IDLE, lock_timeout=1, m0 granted.
REQ-022 m0 write to 37500 then read 37500 -> mem_write=0, readdata=0, readdatavalid=1, oor_err=1.
REQ-023 freeze=1 for 3 cycles after an accepted read -> readdatavalid next cycle, waitrequests=1, mem_clken=0, no grants.
REQ-024 reset_n low one cycle after an accepted read -> no readdatavalid; all outputs at reset values.
